// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: exclusive one-hot grants with a mandatory idle
// gap between holders and a hold timer that preempts long contended grants.

module rr_grant_lane #(
    parameter int ID_W = 2,
    parameter int IDX  = 0
) (
    input  logic [ID_W-1:0] i_ptr,
    input  logic [ID_W-1:0] i_k,
    output logic            o_hi,
    output logic            o_sel
);
    // o_hi marks lanes at or after the pointer (first half of the circular search)
    assign o_hi  = (ID_W'(IDX) >= i_ptr);
    assign o_sel = (ID_W'(IDX) == i_k);
endmodule

module rr_grant_ctrl #(
    parameter  int N        = 4,
    parameter  int HOLD_MAX = 8,
    localparam int ID_W     = $clog2(N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    i_req,
    input  logic [N-1:0]    i_rel,
    output logic [N-1:0]    o_gnt,
    output logic [ID_W-1:0] o_gnt_id,
    output logic            o_busy,
    output logic            o_preempt
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t          r_state, w_state_nxt;
    logic [ID_W-1:0] r_k, w_k_nxt;
    logic [ID_W-1:0] r_ptr, w_ptr_nxt;
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic [N-1:0]    r_gnt, w_gnt_nxt;
    logic            r_preempt, w_preempt_nxt;

    logic [N-1:0]    w_hi_mask;
    logic [N-1:0]    w_k_onehot;
    logic [N-1:0]    w_req_hi;
    logic [ID_W-1:0] w_sel_hi, w_sel_any, w_sel;
    logic [N-1:0]    w_others;
    logic            w_rel_k, w_drop_k, w_timeout, w_release;
    logic [ID_W-1:0] w_k_inc;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_lane
            rr_grant_lane #(.ID_W(ID_W), .IDX(g)) u_lane (
                .i_ptr (r_ptr),
                .i_k   (r_k),
                .o_hi  (w_hi_mask[g]),
                .o_sel (w_k_onehot[g])
            );
        end
    endgenerate

    assign w_req_hi = i_req & w_hi_mask;

    // Lowest index wins inside each half; the upper half (>= ptr) takes precedence.
    always_comb begin
        w_sel_hi  = '0;
        w_sel_any = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_req_hi[i]) w_sel_hi  = ID_W'(i);
            if (i_req[i])    w_sel_any = ID_W'(i);
        end
    end

    assign w_sel     = (|w_req_hi) ? w_sel_hi : w_sel_any;
    assign w_others  = i_req & ~w_k_onehot;
    assign w_rel_k   = |(i_rel & w_k_onehot);
    assign w_drop_k  = ~|(i_req & w_k_onehot);
    assign w_timeout = (|w_others) && (r_cnt == 8'(HOLD_MAX - 1));
    assign w_release = w_rel_k | w_drop_k | w_timeout;
    assign w_k_inc   = (r_k == ID_W'(N - 1)) ? '0 : r_k + ID_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt;
        w_preempt_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_gnt_nxt = '0;
                if (|i_req) begin
                    w_k_nxt     = w_sel;
                    w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_sel;
                    w_cnt_nxt   = '0;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_gnt_nxt     = '0;
                    w_k_nxt       = '0;
                    w_ptr_nxt     = w_k_inc;
                    w_state_nxt   = IDLE;
                    w_preempt_nxt = w_timeout & ~w_rel_k & ~w_drop_k;
                end else if (|w_others && r_cnt != 8'hFF) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_preempt <= w_preempt_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_gnt_id  = r_k;
    assign o_busy    = |r_gnt;
    assign o_preempt = r_preempt;
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl (N=4, HOLD_MAX=4) with an expected-output queue.

module tb_rr_grant_ctrl;
    localparam int N    = 4;
    localparam int ID_W = 2;

    typedef struct packed {
        logic [N-1:0]    gnt;
        logic [ID_W-1:0] id;
        logic            busy;
        logic            pre;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    rel;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            busy;
    logic            preempt;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    rr_grant_ctrl #(.N(N), .HOLD_MAX(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .i_req     (req),
        .i_rel     (rel),
        .o_gnt     (gnt),
        .o_gnt_id  (gnt_id),
        .o_busy    (busy),
        .o_preempt (preempt)
    );

    always #5 clock = ~clock;

    task automatic push(input logic [N-1:0] g, input logic [ID_W-1:0] id,
                        input logic b, input logic p, input string tag);
        exp_t e;
        e.gnt = g; e.id = id; e.busy = b; e.pre = p;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare_head();
        exp_t  e;
        exp_t  o;
        string t;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
            return;
        end
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        o.gnt = gnt; o.id = gnt_id; o.busy = busy; o.pre = preempt;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed gnt=%b id=%0d busy=%b pre=%b expected gnt=%b id=%0d busy=%b pre=%b",
                   t, o.gnt, o.id, o.busy, o.pre, e.gnt, e.id, e.busy, e.pre);
        end
    endtask

    // expect the outputs seen just after the next rising edge
    task automatic tick(input logic [N-1:0] g, input logic [ID_W-1:0] id,
                        input logic p, input string tag);
        push(g, id, |g, p, tag);
        @(posedge clock);
        #1;
        compare_head();
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        rel   = '0;
        #2;
        push(4'b0000, 2'd0, 1'b0, 1'b0, "reset_idle");
        compare_head();
        req = 4'b1111;
        @(posedge clock);
        #1;
        push(4'b0000, 2'd0, 1'b0, 1'b0, "reset_held_edge");
        compare_head();
        #1;
        reset = 1'b0;

        // fair rotation: each holder releases on its 2nd grant cycle
        for (int j = 0; j < N; j++) begin
            tick(4'b0001 << j, ID_W'(j), 1'b0, $sformatf("rot_g%0d_c1", j));
            tick(4'b0001 << j, ID_W'(j), 1'b0, $sformatf("rot_g%0d_c2", j));
            rel = 4'b0001 << j;
            tick(4'b0000, 2'd0, 1'b0, $sformatf("rot_gap%0d", j));
            rel = '0;
        end
        tick(4'b0001, 2'd0, 1'b0, "rot_wrap_g0");

        // preemption: two contenders, HOLD_MAX=4 cycles each
        req = 4'b0011;
        for (int c = 1; c < 4; c++) tick(4'b0001, 2'd0, 1'b0, $sformatf("pre_g0_c%0d", c + 1));
        tick(4'b0000, 2'd0, 1'b1, "pre_gap0");
        for (int c = 0; c < 4; c++) tick(4'b0010, 2'd1, 1'b0, $sformatf("pre_g1_c%0d", c + 1));
        tick(4'b0000, 2'd0, 1'b1, "pre_gap1");
        tick(4'b0001, 2'd0, 1'b0, "pre_back_g0");

        // uncontended holder keeps grant
        req = 4'b0100;
        tick(4'b0000, 2'd0, 1'b0, "unc_withdraw_gap");
        for (int c = 0; c < 20; c++) tick(4'b0100, 2'd2, 1'b0, $sformatf("unc_c%0d", c));

        // withdrawal of holder 2, pointer moves to 3 and wraps to grant 0
        req = 4'b0101;
        tick(4'b0100, 2'd2, 1'b0, "wd_hold");
        req = 4'b0001;
        tick(4'b0000, 2'd0, 1'b0, "wd_gap");
        tick(4'b0001, 2'd0, 1'b0, "wd_wrap_g0");

        // async reset mid-grant
        req = 4'b0100;
        tick(4'b0000, 2'd0, 1'b0, "ar_gap");
        tick(4'b0100, 2'd2, 1'b0, "ar_grant2");
        #2;
        reset = 1'b1;
        req   = 4'b0110;
        #1;
        push(4'b0000, 2'd0, 1'b0, 1'b0, "ar_async_clear");
        compare_head();
        #2;
        reset = 1'b0;
        tick(4'b0010, 2'd1, 1'b0, "ar_after_reset");
        tick(4'b0010, 2'd1, 1'b0, "ar_after_reset_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
